// File: rtl/ustc_fan_collector.sv
// FAN output collector: keeps lanes flagged as final sums, accumulates them per row tag
// across a tile, then drains touched rows in ascending order on the tile's last beat.
module ustc_fan_collector #(
    parameter int NUM_IN  = 32,
    parameter int DW_DATA = 32,
    parameter int DW_ROW  = 5,
    parameter int DW_CTRL = 4,
    parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [NUM_IN*DW_LINE-1:0] in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW_ROW-1:0]         out_row,
    output logic [DW_DATA-1:0]        out_data,
    output logic                      out_last,
    output logic                      busy
);

    localparam int NUM_ROWS = 1 << DW_ROW;

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                state;
    logic [DW_DATA-1:0]    acc [NUM_ROWS];
    logic [NUM_ROWS-1:0]   pending;

    logic [DW_DATA-1:0]    beat_sum [NUM_ROWS];
    logic [NUM_ROWS-1:0]   beat_hit;
    logic [NUM_ROWS-1:0]   pending_next;
    logic [DW_ROW-1:0]     low_row;
    logic                  single;
    logic                  accept;
    logic                  draining;

    // Per-row sum of this beat's flagged lanes; same-beat duplicates add together.
    always_comb begin
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            beat_sum[r] = '0;
        end
        beat_hit = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (in[i*DW_LINE + DW_DATA + DW_ROW]) begin
                beat_sum[in[i*DW_LINE + DW_DATA +: DW_ROW]] =
                    beat_sum[in[i*DW_LINE + DW_DATA +: DW_ROW]] + in[i*DW_LINE +: DW_DATA];
                beat_hit[in[i*DW_LINE + DW_DATA +: DW_ROW]] = 1'b1;
            end
        end
    end

    // Scan from the top so the last hit, i.e. the lowest set index, wins.
    always_comb begin
        low_row = '0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            if (pending[NUM_ROWS-1-i]) begin
                low_row = DW_ROW'(NUM_ROWS-1-i);
            end
        end
    end

    always_comb begin
        draining     = (state == DRAIN);
        accept       = in_valid && (state == ACCUM);
        pending_next = pending | beat_hit;
        single       = (pending != '0) && ((pending & (pending - 1'b1)) == '0);
        in_ready     = (state == ACCUM);
        busy         = draining;
        out_valid    = draining;
        out_row      = draining ? low_row : '0;
        out_data     = draining ? acc[low_row] : '0;
        out_last     = draining && single;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCUM;
            pending <= '0;
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                acc[r] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                            acc[r] <= acc[r] + beat_sum[r];
                        end
                        pending <= pending_next;
                        if (in_last && (pending_next != '0)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        acc[low_row]     <= '0;
                        pending[low_row] <= 1'b0;
                        if (single) begin
                            state <= ACCUM;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_ustc_fan_collector.sv
// Scoreboard bench for ustc_fan_collector: expected results are queued when beats are
// driven and popped by a negedge monitor on every output handshake.
module tb_ustc_fan_collector;

    localparam int NUM_IN  = 32;
    localparam int DW_DATA = 32;
    localparam int DW_ROW  = 5;
    localparam int DW_CTRL = 4;
    localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_last;
    logic [NUM_IN*DW_LINE-1:0] in_bus;
    logic                      out_valid;
    logic                      out_ready;
    logic [DW_ROW-1:0]         out_row;
    logic [DW_DATA-1:0]        out_data;
    logic                      out_last;
    logic                      busy;

    logic [DW_LINE-1:0] lanes [NUM_IN];

    typedef struct packed {
        logic [DW_ROW-1:0]  row;
        logic [DW_DATA-1:0] data;
        logic               last;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    ustc_fan_collector #(
        .NUM_IN (NUM_IN),
        .DW_DATA(DW_DATA),
        .DW_ROW (DW_ROW),
        .DW_CTRL(DW_CTRL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .in       (in_bus),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        in_bus = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_bus[i*DW_LINE +: DW_LINE] = lanes[i];
        end
    end

    // Inputs change 1 time unit after posedge, so at negedge a visible handshake is the one
    // the next posedge will take.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output got row=%0d data=%h last=%0b, expected no output",
                         out_row, out_data, out_last);
            end else begin
                e = sb.pop_front();
                if ({out_row, out_data, out_last} !== {e.row, e.data, e.last}) begin
                    miscompares++;
                    $display("FAIL result got row=%0d data=%h last=%0b, expected row=%0d data=%h last=%0b",
                             out_row, out_data, out_last, e.row, e.data, e.last);
                end
            end
        end
    end

    task automatic clear_lanes();
        for (int i = 0; i < NUM_IN; i++) lanes[i] = '0;
    endtask

    task automatic set_lane(input int lane, input logic [3:0] ctrl, input logic [4:0] row,
                            input logic [31:0] data);
        lanes[lane] = {ctrl, row, data};
    endtask

    task automatic push_exp(input logic [4:0] row, input logic [31:0] data, input logic last);
        exp_t e;
        e.row = row; e.data = data; e.last = last;
        sb.push_back(e);
    endtask

    // Called at posedge+1 while the collector is in ACCUM; returns at posedge+1 of cycle N+1.
    task automatic send_beat(input logic last);
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drained(input int budget, input bit rand_ready);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < budget) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        if (sb.size() != 0 || out_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout got %0d results still queued, out_valid=%0b, expected 0 and 0",
                     sb.size(), out_valid);
            sb.delete();
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        clear_lanes();
        #1;
        vectors++;
        if ({out_valid, out_last, busy, in_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_flags got v/l/b/r=%b, expected 0001",
                     {out_valid, out_last, busy, in_ready});
        end
        vectors++;
        if ({out_row, out_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got row=%0d data=%h, expected 0 and 0", out_row, out_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_two_rows();
        clear_lanes();
        set_lane(8, 4'b0001, 5'd3, 32'd10);
        set_lane(15, 4'b0001, 5'd7, 32'd20);
        push_exp(5'd3, 32'd10, 1'b0);
        push_exp(5'd7, 32'd20, 1'b1);
        out_ready = 1'b1;
        send_beat(1'b1);
        vectors++;
        if ({out_valid, out_row, out_data, out_last, in_ready, busy} !== {1'b1, 5'd3, 32'd10, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL two_rows_n1 got v=%0b row=%0d data=%h last=%0b rdy=%0b, expected 1 3 0000000a 0 0",
                     out_valid, out_row, out_data, out_last, in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, out_row, out_data, out_last} !== {1'b1, 5'd7, 32'd20, 1'b1}) begin
            miscompares++;
            $display("FAIL two_rows_n2 got v=%0b row=%0d data=%h last=%0b, expected 1 7 00000014 1",
                     out_valid, out_row, out_data, out_last);
        end
        @(posedge clk); #1;
        vectors++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL two_rows_n3 got rdy/v/busy=%b, expected 100", {in_ready, out_valid, busy});
        end
        wait_drained(10, 1'b0);
    endtask

    task automatic test_wrap();
        clear_lanes();
        set_lane(2, 4'b0001, 5'd3, 32'd5);
        send_beat(1'b0);
        clear_lanes();
        set_lane(20, 4'b0001, 5'd3, 32'hFFFF_FFFF);
        push_exp(5'd3, 32'h0000_0004, 1'b1);
        send_beat(1'b1);
        wait_drained(10, 1'b0);
    endtask

    task automatic test_dup_lanes();
        clear_lanes();
        set_lane(0, 4'b0001, 5'd9, 32'd1);
        set_lane(31, 4'b1111, 5'd9, 32'd2);
        set_lane(5, 4'b1110, 5'd9, 32'd100);
        push_exp(5'd9, 32'd3, 1'b1);
        send_beat(1'b1);
        wait_drained(10, 1'b0);
    endtask

    task automatic test_backpressure();
        clear_lanes();
        set_lane(3, 4'b0001, 5'd2, 32'h11);
        set_lane(10, 4'b0001, 5'd4, 32'h22);
        push_exp(5'd2, 32'h11, 1'b0);
        push_exp(5'd4, 32'h22, 1'b1);
        out_ready = 1'b0;
        send_beat(1'b1);
        clear_lanes();
        set_lane(1, 4'b0001, 5'd6, 32'h99);
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if ({out_valid, out_row, out_data, out_last, in_ready, busy} !== {1'b1, 5'd2, 32'h11, 1'b0, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d got v=%0b row=%0d data=%h last=%0b rdy=%0b busy=%0b, expected 1 2 00000011 0 0 1",
                         c, out_valid, out_row, out_data, out_last, in_ready, busy);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear_lanes();
        out_ready = 1'b1;
        wait_drained(10, 1'b0);
    endtask

    task automatic test_empty_tile();
        clear_lanes();
        set_lane(6, 4'b1110, 5'd0, 32'd55);
        set_lane(7, 4'b0000, 5'd12, 32'd8);
        send_beat(1'b1);
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if ({out_valid, in_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL empty_tile cycle %0d got v/rdy=%b, expected 01", c, {out_valid, in_ready});
            end
            @(posedge clk); #1;
        end
        clear_lanes();
        set_lane(4, 4'b0001, 5'd0, 32'd7);
        push_exp(5'd0, 32'd7, 1'b1);
        send_beat(1'b1);
        wait_drained(10, 1'b0);
    endtask

    task automatic test_async_reset();
        clear_lanes();
        set_lane(0, 4'b0001, 5'd1, 32'hA);
        set_lane(1, 4'b0001, 5'd5, 32'hB);
        set_lane(2, 4'b0001, 5'd12, 32'hC);
        out_ready = 1'b0;
        send_beat(1'b1);
        @(posedge clk); #1;
        vectors++;
        if ({busy, out_valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL pre_reset_drain got busy/v=%b, expected 11", {busy, out_valid});
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, in_ready, busy, out_last} !== 4'b0100) begin
            miscompares++;
            $display("FAIL async_reset got v/rdy/busy/last=%b, expected 0100",
                     {out_valid, in_ready, busy, out_last});
        end
        vectors++;
        if ({out_row, out_data} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_data got row=%0d data=%h, expected 0 and 0", out_row, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        clear_lanes();
        set_lane(17, 4'b0001, 5'd1, 32'd2);
        push_exp(5'd1, 32'd2, 1'b1);
        send_beat(1'b1);
        wait_drained(10, 1'b0);
    endtask

    task automatic test_random_tiles();
        logic [31:0] m_acc [32];
        logic [31:0] m_pend;
        logic [4:0]  row;
        logic [31:0] data;
        int          nbeats;
        int          left;
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < 32; r++) m_acc[r] = '0;
            m_pend = '0;
            nbeats = $urandom_range(1, 4);
            for (int b = 0; b < nbeats; b++) begin
                clear_lanes();
                for (int i = 0; i < NUM_IN; i++) begin
                    row  = (t % 2 == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                    data = $urandom;
                    if ($urandom_range(0, 3) == 0) begin
                        set_lane(i, {3'($urandom_range(0, 7)), 1'b1}, row, data);
                        m_acc[row] = m_acc[row] + data;
                        m_pend[row] = 1'b1;
                    end else begin
                        set_lane(i, {3'($urandom_range(0, 7)), 1'b0}, row, data);
                    end
                end
                if (b == nbeats - 1) begin
                    left = $countones(m_pend);
                    for (int r = 0; r < 32; r++) begin
                        if (m_pend[r]) begin
                            left--;
                            push_exp(5'(r), m_acc[r], left == 0);
                        end
                    end
                end
                send_beat(b == nbeats - 1);
            end
            clear_lanes();
            wait_drained(300, 1'b1);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_two_rows();
        test_wrap();
        test_dup_lanes();
        test_backpressure();
        test_empty_tile();
        test_async_reset();
        test_random_tiles();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
